// File: rtl/tap_pkg.sv
// Shared TAP definitions: 1149.1 state encoding, the TMS transition graph and
// a helper that classifies the states lying between a capture and an update.
package tap_pkg;

  typedef enum logic [3:0] {
    TLR    = 4'hF,
    RTI    = 4'hC,
    SEL_DR = 4'h7,
    CAP_DR = 4'h6,
    SH_DR  = 4'h2,
    EX1_DR = 4'h1,
    PAU_DR = 4'h3,
    EX2_DR = 4'h0,
    UPD_DR = 4'h5,
    SEL_IR = 4'h4,
    CAP_IR = 4'hE,
    SH_IR  = 4'hA,
    EX1_IR = 4'h9,
    PAU_IR = 4'hB,
    EX2_IR = 4'h8,
    UPD_IR = 4'hD
  } tap_state_t;

  function automatic tap_state_t tap_next(input tap_state_t state, input logic tms);
    tap_state_t nxt;
    case (state)
      TLR:     nxt = tms ? TLR    : RTI;
      RTI:     nxt = tms ? SEL_DR : RTI;
      SEL_DR:  nxt = tms ? SEL_IR : CAP_DR;
      CAP_DR:  nxt = tms ? EX1_DR : SH_DR;
      SH_DR:   nxt = tms ? EX1_DR : SH_DR;
      EX1_DR:  nxt = tms ? UPD_DR : PAU_DR;
      PAU_DR:  nxt = tms ? EX2_DR : PAU_DR;
      EX2_DR:  nxt = tms ? UPD_DR : SH_DR;
      UPD_DR:  nxt = tms ? SEL_DR : RTI;
      SEL_IR:  nxt = tms ? TLR    : CAP_IR;
      CAP_IR:  nxt = tms ? EX1_IR : SH_IR;
      SH_IR:   nxt = tms ? EX1_IR : SH_IR;
      EX1_IR:  nxt = tms ? UPD_IR : PAU_IR;
      PAU_IR:  nxt = tms ? EX2_IR : PAU_IR;
      EX2_IR:  nxt = tms ? UPD_IR : SH_IR;
      UPD_IR:  nxt = tms ? SEL_DR : RTI;
      default: nxt = TLR;
    endcase
    return nxt;
  endfunction

  // True while a scan is in flight (captured but not yet updated).
  function automatic logic tap_mid_scan(input tap_state_t state);
    logic mid;
    case (state)
      CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR,
      CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR: mid = 1'b1;
      default:                               mid = 1'b0;
    endcase
    return mid;
  endfunction

endpackage

// File: rtl/tap_fsm.sv
// TAP state register with next-state logic and per-state action strobes.
// Strobes are decoded from the registered state; the action happens on the next edge.
module tap_fsm
  import tap_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_tms,
  output tap_state_t o_state,
  output logic       o_tlr,
  output logic       o_cap_dr,
  output logic       o_sh_dr,
  output logic       o_upd_dr,
  output logic       o_cap_ir,
  output logic       o_sh_ir,
  output logic       o_upd_ir
);

  tap_state_t r_state;
  tap_state_t w_next;

  // State register; reset overrides TMS.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= TLR;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and strobe decode.
  always_comb begin
    w_next   = tap_next(r_state, i_tms);
    o_tlr    = 1'b0;
    o_cap_dr = 1'b0;
    o_sh_dr  = 1'b0;
    o_upd_dr = 1'b0;
    o_cap_ir = 1'b0;
    o_sh_ir  = 1'b0;
    o_upd_ir = 1'b0;
    case (r_state)
      TLR:     o_tlr    = 1'b1;
      CAP_DR:  o_cap_dr = 1'b1;
      SH_DR:   o_sh_dr  = 1'b1;
      UPD_DR:  o_upd_dr = 1'b1;
      CAP_IR:  o_cap_ir = 1'b1;
      SH_IR:   o_sh_ir  = 1'b1;
      UPD_IR:  o_upd_ir = 1'b1;
      default: o_tlr    = 1'b0;
    endcase
  end

  assign o_state = r_state;

endmodule

// File: rtl/tap_ctrl_param.sv
// Parametrised 1149.1 TAP: IR, IDCODE/USER/BYPASS data registers and TDO mux,
// with the raw state code mirrored on four observation pads.
module tap_ctrl_param
  import tap_pkg::*;
#(
  parameter int              IR_W       = 4,
  parameter int              DR_W       = 8,
  parameter logic [31:0]     IDCODE_VAL = 32'h1000_0001,
  parameter logic [IR_W-1:0] IR_IDCODE  = IR_W'(4'b0001),
  parameter logic [IR_W-1:0] IR_USER    = IR_W'(4'b0010)
) (
  input  logic            GCLK_Pad,
  input  logic            TRST_N_Pad,
  input  logic            TMS_Pad,
  input  logic            TDI_Pad,
  output logic            TDO_Pad,
  output logic            state_obs0_Pad,
  output logic            state_obs1_Pad,
  output logic            state_obs2_Pad,
  output logic            state_obs3_Pad,
  output logic [IR_W-1:0] ir_out,
  output logic [DR_W-1:0] user_dr_out,
  input  logic [DR_W-1:0] user_dr_in,
  output logic            user_upd
);

  tap_state_t      w_state;
  logic            w_tlr, w_cap_dr, w_sh_dr, w_upd_dr, w_cap_ir, w_sh_ir, w_upd_ir;
  logic            w_sel_id, w_sel_user, w_sel_byp;
  logic [IR_W-1:0] r_ir_sr, r_ir_out;
  logic [31:0]     r_id_sr;
  logic [DR_W-1:0] r_user_sr, r_user_dr_out;
  logic            r_byp, r_user_upd;

  tap_fsm u_fsm (
    .i_clk    (GCLK_Pad),
    .i_rst_n  (TRST_N_Pad),
    .i_tms    (TMS_Pad),
    .o_state  (w_state),
    .o_tlr    (w_tlr),
    .o_cap_dr (w_cap_dr),
    .o_sh_dr  (w_sh_dr),
    .o_upd_dr (w_upd_dr),
    .o_cap_ir (w_cap_ir),
    .o_sh_ir  (w_sh_ir),
    .o_upd_ir (w_upd_ir)
  );

  // DR select follows the updated instruction, which cannot change during a DR scan.
  always_comb begin
    w_sel_id   = (r_ir_out == IR_IDCODE);
    w_sel_user = (r_ir_out == IR_USER) && !w_sel_id;
    w_sel_byp  = !w_sel_id && !w_sel_user;
  end

  // Instruction shift register and instruction latch.
  always_ff @(posedge GCLK_Pad) begin
    if (!TRST_N_Pad) begin
      r_ir_sr  <= '0;
      r_ir_out <= IR_IDCODE;
    end else begin
      if (w_cap_ir) begin
        r_ir_sr <= IR_W'(2'b01);
      end else if (w_sh_ir) begin
        r_ir_sr <= (r_ir_sr >> 1) | (IR_W'(TDI_Pad) << (IR_W - 1));
      end
      if (w_tlr) begin
        r_ir_out <= IR_IDCODE;
      end else if (w_upd_ir) begin
        r_ir_out <= r_ir_sr;
      end
    end
  end

  // IDCODE and BYPASS data registers.
  always_ff @(posedge GCLK_Pad) begin
    if (!TRST_N_Pad) begin
      r_id_sr <= 32'h0;
      r_byp   <= 1'b0;
    end else begin
      if (w_cap_dr && w_sel_id) begin
        r_id_sr <= IDCODE_VAL;
      end else if (w_sh_dr && w_sel_id) begin
        r_id_sr <= {TDI_Pad, r_id_sr[31:1]};
      end
      if (w_cap_dr && w_sel_byp) begin
        r_byp <= 1'b0;
      end else if (w_sh_dr && w_sel_byp) begin
        r_byp <= TDI_Pad;
      end
    end
  end

  // User data register; a reset mid-scan keeps the last update, otherwise clears it.
  always_ff @(posedge GCLK_Pad) begin
    if (!TRST_N_Pad) begin
      r_user_sr  <= '0;
      r_user_upd <= 1'b0;
      if (!tap_mid_scan(w_state)) begin
        r_user_dr_out <= '0;
      end
    end else begin
      r_user_upd <= w_upd_dr && w_sel_user;
      if (w_cap_dr && w_sel_user) begin
        r_user_sr <= user_dr_in;
      end else if (w_sh_dr && w_sel_user) begin
        r_user_sr <= (r_user_sr >> 1) | (DR_W'(TDI_Pad) << (DR_W - 1));
      end
      if (w_upd_dr && w_sel_user) begin
        r_user_dr_out <= r_user_sr;
      end
    end
  end

  // TDO is driven only while shifting.
  always_comb begin
    TDO_Pad = 1'b0;
    case (w_state)
      SH_IR: TDO_Pad = r_ir_sr[0];
      SH_DR: begin
        if (w_sel_id) begin
          TDO_Pad = r_id_sr[0];
        end else if (w_sel_user) begin
          TDO_Pad = r_user_sr[0];
        end else begin
          TDO_Pad = r_byp;
        end
      end
      default: TDO_Pad = 1'b0;
    endcase
  end

  assign state_obs0_Pad = w_state[0];
  assign state_obs1_Pad = w_state[1];
  assign state_obs2_Pad = w_state[2];
  assign state_obs3_Pad = w_state[3];
  assign ir_out         = r_ir_out;
  assign user_dr_out    = r_user_dr_out;
  assign user_upd       = r_user_upd;

endmodule

// File: tb/tb_tap_ctrl_param.sv
// Directed bench for tap_ctrl_param: table-driven state walk plus hand-written
// scan sequences (IDCODE, user DR, bypass, resets during a scan).
module tb_tap_ctrl_param;

  logic       clk = 1'b0;
  logic       trst_n = 1'b0;
  logic       tms = 1'b1;
  logic       tdi = 1'b0;
  logic       tdo;
  logic       o0, o1, o2, o3;
  logic [3:0] ir;
  logic [7:0] udr_out;
  logic [7:0] udr_in = 8'h00;
  logic       uupd;
  logic [3:0] obs;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic       tms;
    logic [3:0] obs;
    logic       tdo;
  } vec_t;

  vec_t walk[22];

  tap_ctrl_param dut (
    .GCLK_Pad       (clk),
    .TRST_N_Pad     (trst_n),
    .TMS_Pad        (tms),
    .TDI_Pad        (tdi),
    .TDO_Pad        (tdo),
    .state_obs0_Pad (o0),
    .state_obs1_Pad (o1),
    .state_obs2_Pad (o2),
    .state_obs3_Pad (o3),
    .ir_out         (ir),
    .user_dr_out    (udr_out),
    .user_dr_in     (udr_in),
    .user_upd       (uupd)
  );

  assign obs = {o3, o2, o1, o0};

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input logic t_tms, input logic t_tdi);
    tms = t_tms;
    tdi = t_tdi;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    trst_n = 1'b0;
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    trst_n = 1'b1;
  endtask

  // From TLR (from_tlr=1) or RTI, load a 4-bit instruction and end in RTI.
  task automatic load_ir(input logic [3:0] val, input logic from_tlr);
    if (from_tlr) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick(i == 3, val[i]);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    check("ir_load", {28'h0, ir}, {28'h0, val});
  endtask

  // RTI -> SelDR -> CapDR -> ShDR.
  task automatic enter_shdr();
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] got32;
    logic [7:0]  got8;
    logic [7:0]  pat;
    logic [3:0]  got4;
    logic [3:0]  bits;

    walk[0]  = '{1'b0, 4'hC, 1'b0};
    walk[1]  = '{1'b1, 4'h7, 1'b0};
    walk[2]  = '{1'b0, 4'h6, 1'b0};
    walk[3]  = '{1'b0, 4'h2, 1'b1};
    walk[4]  = '{1'b1, 4'h1, 1'b0};
    walk[5]  = '{1'b0, 4'h3, 1'b0};
    walk[6]  = '{1'b1, 4'h0, 1'b0};
    walk[7]  = '{1'b1, 4'h5, 1'b0};
    walk[8]  = '{1'b1, 4'h7, 1'b0};
    walk[9]  = '{1'b1, 4'h4, 1'b0};
    walk[10] = '{1'b0, 4'hE, 1'b0};
    walk[11] = '{1'b0, 4'hA, 1'b1};
    walk[12] = '{1'b1, 4'h9, 1'b0};
    walk[13] = '{1'b0, 4'hB, 1'b0};
    walk[14] = '{1'b1, 4'h8, 1'b0};
    walk[15] = '{1'b0, 4'hA, 1'b0};
    walk[16] = '{1'b1, 4'h9, 1'b0};
    walk[17] = '{1'b1, 4'hD, 1'b0};
    walk[18] = '{1'b1, 4'h7, 1'b0};
    walk[19] = '{1'b1, 4'h4, 1'b0};
    walk[20] = '{1'b1, 4'hF, 1'b0};
    walk[21] = '{1'b0, 4'hC, 1'b0};

    // Reset state
    do_reset();
    check("rst_obs", {28'h0, obs}, 32'hF);
    check("rst_ir", {28'h0, ir}, 32'h1);
    check("rst_tdo", {31'h0, tdo}, 32'h0);
    check("rst_udr", {24'h0, udr_out}, 32'h0);
    check("rst_upd", {31'h0, uupd}, 32'h0);

    // Full TMS graph walk, checking state code and TDO at each step
    for (int i = 0; i < 22; i++) begin
      tick(walk[i].tms, 1'b0);
      check($sformatf("walk_obs[%0d]", i), {28'h0, obs}, {28'h0, walk[i].obs});
      check($sformatf("walk_tdo[%0d]", i), {31'h0, tdo}, {31'h0, walk[i].tdo});
    end

    // Five TMS=1 reach TLR from every state on the walk
    for (int k = 0; k <= 22; k++) begin
      do_reset();
      for (int j = 0; j < k; j++) tick(walk[j].tms, 1'b0);
      repeat (5) tick(1'b1, 1'b0);
      check($sformatf("tlr_from_step%0d", k), {28'h0, obs}, 32'hF);
    end

    // IDCODE read
    do_reset();
    tick(1'b0, 1'b0);
    enter_shdr();
    check("id_first_bit", {31'h0, tdo}, 32'h1);
    for (int i = 0; i < 32; i++) begin
      got32[i] = tdo;
      tick(i == 31, 1'b0);
    end
    check("idcode", got32, 32'h1000_0001);
    check("id_exit_obs", {28'h0, obs}, 32'h1);

    // User DR write with capture of user_dr_in
    do_reset();
    udr_in = 8'h3C;
    pat = 8'hA5;
    load_ir(4'b0010, 1'b1);
    enter_shdr();
    for (int i = 0; i < 8; i++) begin
      got8[i] = tdo;
      tick(i == 7, pat[i]);
    end
    check("user_capture_out", {24'h0, got8}, 32'h3C);
    tick(1'b1, 1'b0);
    check("upd_in_upddr", {31'h0, uupd}, 32'h0);
    check("udr_before_upd", {24'h0, udr_out}, 32'h0);
    tick(1'b0, 1'b0);
    check("upd_pulse", {31'h0, uupd}, 32'h1);
    check("udr_a5", {24'h0, udr_out}, 32'hA5);
    tick(1'b0, 1'b0);
    check("upd_single", {31'h0, uupd}, 32'h0);

    // Reset after 4 bits of a user DR shift keeps the previous update
    enter_shdr();
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1);
    trst_n = 1'b0;
    tick(1'b0, 1'b0);
    trst_n = 1'b1;
    check("midrst_obs", {28'h0, obs}, 32'hF);
    check("midrst_ir", {28'h0, ir}, 32'h1);
    check("midrst_udr", {24'h0, udr_out}, 32'hA5);
    check("midrst_upd", {31'h0, uupd}, 32'h0);
    tick(1'b1, 1'b0);
    check("midrst_upd_next", {31'h0, uupd}, 32'h0);

    // Reset on the UpdDR exit edge wins: no update, user_dr_out cleared
    udr_in = 8'h00;
    pat = 8'h5A;
    load_ir(4'b0010, 1'b1);
    enter_shdr();
    for (int i = 0; i < 8; i++) tick(i == 7, pat[i]);
    tick(1'b1, 1'b0);
    check("upddr_obs", {28'h0, obs}, 32'h5);
    trst_n = 1'b0;
    tick(1'b0, 1'b0);
    trst_n = 1'b1;
    check("updrst_udr", {24'h0, udr_out}, 32'h0);
    check("updrst_upd", {31'h0, uupd}, 32'h0);
    check("updrst_obs", {28'h0, obs}, 32'hF);

    // Bypass: one-cycle delay with a leading 0 from capture
    do_reset();
    load_ir(4'b1111, 1'b1);
    enter_shdr();
    bits = 4'b1101;
    for (int i = 0; i < 4; i++) begin
      got4[i] = tdo;
      tick(i == 3, bits[i]);
    end
    check("bypass_tdo", {28'h0, got4}, 32'hA);
    check("bypass_no_upd", {24'h0, udr_out}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tap_ctrl_param.md
# tap_ctrl_param

Parametrised IEEE 1149.1 TAP controller, successor to the fixed 4-bit-observation TAP route. It adds an instruction register of width `IR_W`, IDCODE, BYPASS and one user data register of width `DR_W`, and adds TDI/TDO serial paths. The 4-bit state observation outputs are kept, so existing state-walk benches remain usable. It sits directly behind the pad ring and drives the chip's test-configuration register.

## Interface
- `IR_W`, default 4: instruction register width, minimum 2.
- `DR_W`, default 8: user data register width, minimum 1.
- `IDCODE_VAL`, default 32'h1000_0001: device ID; bit 0 must be 1.
- `IR_IDCODE`, default 4'b0001: opcode that selects the 32-bit IDCODE DR.
- `IR_USER`, default 4'b0010: opcode that selects the user DR.
- Any other opcode, including all-ones, selects BYPASS.
- `GCLK_Pad` in, 1 bit: sole clock; all state changes on the rising edge.
- `TRST_N_Pad` in, 1 bit: reset, synchronous, active-low.
- `TMS_Pad` in, 1 bit: test mode select, sampled on the rising edge.
- `TDI_Pad` in, 1 bit: serial data in, sampled on the rising edge.
- `TDO_Pad` out, 1 bit: serial data out.
- `state_obs0_Pad`..`state_obs3_Pad` out, 1 bit each: current state code, bit 0..3.
- `ir_out` out, `IR_W` bits: current (updated) instruction.
- `user_dr_out` out, `DR_W` bits: user DR parallel output.
- `user_dr_in` in, `DR_W` bits: value loaded into the user shift register at Capture-DR.
- `user_upd` out, 1 bit: one-cycle pulse when the user DR is updated.

## Operation
- State machine: 16 states, standard 1149.1 encoding. Transitions follow the standard TMS graph.
  - TLR=F, RTI=C
  - SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PauDR=3, Ex2DR=0, UpdDR=5
  - SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PauIR=B, Ex2IR=8, UpdIR=D
- `state_obs[3:0]` is the registered state code.
- Five consecutive TMS=1 cycles reach TLR from any state.
- Instruction register:
  - On every cycle spent in TLR, `ir_out` is set to `IR_IDCODE`.
  - CapIR loads the IR shift register with {0…0, 2'b01}.
  - ShIR shifts the IR shift register as sr <= {TDI, sr[IR_W-1:1]}.
  - UpdIR copies the IR shift register into `ir_out`.
- DR selection is decoded from `ir_out` and held for the whole DR scan.
- IDCODE DR (32 bits): CapDR loads `IDCODE_VAL`; ShDR shifts LSB-first.
- User DR (`DR_W` bits):
  - CapDR loads `user_dr_in`; ShDR shifts LSB-first.
  - UpdDR copies the shift register into `user_dr_out` and asserts `user_upd` for the following cycle.
- BYPASS DR (1 bit): CapDR loads 0; ShDR loads TDI.
- `TDO_Pad` is combinational from registered state:
  - in ShIR: bit 0 of the IR shift register;
  - in ShDR: bit 0 of the selected DR;
  - in all other states: 0.
- Pause and Exit states hold every shift register unchanged.

## Timing
- Reset (`TRST_N_Pad`=0 at a rising edge) sets the following on that edge:
  - state = TLR (obs = 4'hF);
  - `ir_out` = `IR_IDCODE`;
  - `user_dr_out` = 0, `user_upd` = 0;
  - all shift registers = 0.
- Reset has priority over TMS. Reset in mid-shift discards the partial scan and leaves `user_dr_out` unchanged from its previous update — except a reset that asserts at the same edge as an UpdDR exit, in which case reset wins and `user_dr_out` = 0.
- Shift timing:
  - The first `TDO_Pad` bit is valid in the cycle the FSM enters ShDR/ShIR.
  - Each rising edge while in Shift shifts one bit.
  - The edge that leaves Shift (TMS=1) also shifts one bit.
  - Total latency TDI→TDO through a register of width N is N clocks.
- `user_upd` is high exactly in the cycle after UpdDR, only when the user DR is selected.
- Clock period is independent of the logic: only single-edge, single-clock registers are used.

## Structure
- Package `tap_pkg` holds:
  - the 4-bit state enum `tap_state_t` with the encodings above;
  - a next-state function `tap_next(state, tms)`.
- Sub-module `tap_fsm`: state register plus next-state logic, with outputs for the current state and decoded capture/shift/update strobes.
- Top level `tap_ctrl_param` contains the IR, the DR muxing and the TDO mux.

## Test plan
- Reset: hold `TRST_N_Pad`=0 for 1 edge → obs = F, `ir_out` = 0001, `TDO_Pad` = 0, `user_dr_out` = 0.
- State walk: from each of the 16 states, apply TMS=1 ×5 → obs = F. Apply TMS sequence 0,1,0,0 from TLR → obs = C, 7, 6, 2.
- IDCODE read: from TLR apply TMS 0,1,0,0, then 32 shift cycles → TDO yields 32'h1000_0001 LSB-first; first bit = 1.
- User write: shift IR = 0010 through ShIR/UpdIR, then DR-scan TDI = 0xA5 LSB-first → `user_dr_out` = 8'hA5 and `user_upd` is a single-cycle pulse. A capture with `user_dr_in` = 8'h3C shifts 3C out on TDO.
- Bypass: IR = 1111, then shift 1,0,1,1 → TDO = 0,1,0,1 (one-cycle delay, leading 0 from capture).
- Reset mid-ShDR of the user DR after 4 bits → obs = F, `ir_out` = 0001, `user_dr_out` = previous value (no `user_upd`).
